// File: rtl/sequential_unsort_if.sv
// Stream bundle between a sorted-word producer and sequential_unsort.
// The master drives words in; the slave returns them in index order with rank.
interface sequential_unsort_if #(
  parameter int unsigned VAL_W = 8,
  parameter int unsigned IDX_W = 4
);
  logic                     InValid;
  logic [VAL_W+IDX_W-1:0]   DataIn;
  logic [VAL_W+IDX_W-1:0]   DataOut;
  logic [IDX_W-1:0]         Rank;
  logic                     OutValid;
  logic                     Busy;
  logic                     Error;

  modport master (
    output InValid, DataIn,
    input  DataOut, Rank, OutValid, Busy, Error
  );

  modport slave (
    input  InValid, DataIn,
    output DataOut, Rank, OutValid, Busy, Error
  );
endinterface

// File: rtl/sequential_unsort.sv
// Inverse of the sequential sorter: collects a frame of N sorted words, then
// re-emits them in original index order with each word's arrival rank.
module sequential_unsort #(
  parameter int unsigned N     = 12,
  parameter int unsigned VAL_W = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  sequential_unsort_if.slave  bus
);

  localparam int unsigned DW = VAL_W + IDX_W;
  localparam int unsigned CW = IDX_W + 1;

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_EMIT    = 1'b1;

  logic [0:0]       r_state,    w_state_nxt;
  logic [CW-1:0]    r_cnt,      w_cnt_nxt;
  logic [IDX_W-1:0] r_ptr,      w_ptr_nxt;
  logic [N-1:0]     r_seen,     w_seen_nxt;
  logic [DW-1:0]    r_data_out, w_data_nxt;
  logic [IDX_W-1:0] r_rank,     w_rank_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_busy;
  logic             r_error,    w_error_nxt;
  logic             w_wr_en;

  logic [VAL_W-1:0] r_mem_val  [N];
  logic [IDX_W-1:0] r_mem_rank [N];

  logic [IDX_W-1:0] w_in_idx;
  logic [VAL_W-1:0] w_in_val;
  logic             w_idx_ok;
  logic             w_slot_free;

  assign w_in_idx    = bus.DataIn[IDX_W-1:0];
  assign w_in_val    = bus.DataIn[DW-1:IDX_W];
  assign w_idx_ok    = {1'b0, w_in_idx} < CW'(N);
  assign w_slot_free = w_idx_ok && !r_seen[w_in_idx];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ptr_nxt       = r_ptr;
    w_seen_nxt      = r_seen;
    w_data_nxt      = r_data_out;
    w_rank_nxt      = r_rank;
    w_out_valid_nxt = 1'b0;
    w_error_nxt     = r_error;
    w_wr_en         = 1'b0;

    case (r_state)
      S_COLLECT: begin
        if (bus.InValid) begin
          if (w_slot_free) begin
            w_wr_en              = 1'b1;
            w_seen_nxt[w_in_idx] = 1'b1;
          end else begin
            w_error_nxt = 1'b1;
          end
          // A rejected word still consumes its rank
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            w_state_nxt = S_EMIT;
            w_ptr_nxt   = '0;
          end
        end
      end
      S_EMIT: begin
        w_out_valid_nxt = 1'b1;
        if (r_seen[r_ptr]) begin
          w_data_nxt = {r_mem_val[r_ptr], r_ptr};
          w_rank_nxt = r_mem_rank[r_ptr];
        end else begin
          w_data_nxt = {VAL_W'(0), r_ptr};
          w_rank_nxt = '1;
        end
        if (bus.InValid) begin
          w_error_nxt = 1'b1;
        end
        if (r_ptr == IDX_W'(N - 1)) begin
          w_state_nxt = S_COLLECT;
          w_cnt_nxt   = '0;
          w_seen_nxt  = '0;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_COLLECT;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_seen      <= '0;
      r_data_out  <= '0;
      r_rank      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_seen      <= w_seen_nxt;
      r_data_out  <= w_data_nxt;
      r_rank      <= w_rank_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= (w_state_nxt == S_EMIT);
      r_error     <= w_error_nxt;
    end
  end

  // Frame storage; contents are masked by r_seen, so no reset is needed
  always_ff @(posedge Clk) begin
    if (w_wr_en && !Reset) begin
      r_mem_val[w_in_idx]  <= w_in_val;
      r_mem_rank[w_in_idx] <= r_cnt[IDX_W-1:0];
    end
  end

  assign bus.DataOut  = r_data_out;
  assign bus.Rank     = r_rank;
  assign bus.OutValid = r_out_valid;
  assign bus.Busy     = r_busy;
  assign bus.Error    = r_error;

endmodule

// File: tb/tb_sequential_unsort.sv
// Self-checking bench for sequential_unsort: directed frames plus randomized
// frames, compared against an arrival-list reference model.
module tb_sequential_unsort;

  localparam int unsigned N     = 12;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned DW    = VAL_W + IDX_W;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  sequential_unsort_if #(.VAL_W(VAL_W), .IDX_W(IDX_W)) bus ();

  sequential_unsort #(.N(N), .VAL_W(VAL_W), .IDX_W(IDX_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        m_err;

  logic [DW-1:0]    nom   [N];
  logic [DW-1:0]    rev   [N];
  logic [DW-1:0]    wbuf  [N];
  logic [VAL_W-1:0] tab_v [N];
  logic [IDX_W-1:0] tab_r [N];
  logic [DW-1:0]    cap_d [N];
  logic [IDX_W-1:0] cap_r [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset       = 1'b1;
    bus.InValid = 1'b0;
    bus.DataIn  = '0;
    tick;
    tick;
    check("rst_dout", 32'(bus.DataOut), 32'd0);
    check("rst_rank", 32'(bus.Rank), 32'd0);
    check("rst_ov",   32'(bus.OutValid), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_err",  32'(bus.Error), 32'd0);
    Reset = 1'b0;
    m_err = 1'b0;
  endtask

  // Drives one frame (optional gap, overrun word, or reset during emit) and
  // checks every output cycle against the reference model.
  task automatic run_frame(input logic [DW-1:0] w [N], input int gap_pos, input int gap_len,
                           input int ovr_k, input int rst_k);
    logic [VAL_W-1:0] ev [N];
    logic [IDX_W-1:0] er [N];
    bit               bad [N];
    // Reference: output k is the first arrival carrying index k, else empty
    for (int k = 0; k < N; k++) begin
      ev[k] = '0;
      er[k] = '1;
      for (int r = N - 1; r >= 0; r--) begin
        if (int'(w[r][IDX_W-1:0]) == k) begin
          ev[k] = w[r][DW-1:IDX_W];
          er[k] = IDX_W'(r);
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      bad[r] = (int'(w[r][IDX_W-1:0]) >= N);
      for (int q = 0; q < r; q++)
        if (w[q][IDX_W-1:0] == w[r][IDX_W-1:0]) bad[r] = 1'b1;
    end

    for (int j = 0; j < N; j++) begin
      if (j == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.InValid = 1'b0;
          tick;
          check("gap_ov",  32'(bus.OutValid), 32'd0);
          check("gap_err", 32'(bus.Error), 32'(m_err));
        end
      end
      bus.InValid = 1'b1;
      bus.DataIn  = w[j];
      if (bad[j]) m_err = 1'b1;
      tick;
      bus.InValid = 1'b0;
      check("col_err",  32'(bus.Error), 32'(m_err));
      check("col_busy", 32'(bus.Busy), 32'(j == N - 1));
      check("col_ov",   32'(bus.OutValid), 32'd0);
    end

    for (int k = 0; k < N; k++) begin
      if (k == rst_k) begin
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        m_err = 1'b0;
        check("mrst_ov",   32'(bus.OutValid), 32'd0);
        check("mrst_busy", 32'(bus.Busy), 32'd0);
        check("mrst_err",  32'(bus.Error), 32'd0);
        return;
      end
      if (k == ovr_k) begin
        bus.InValid = 1'b1;
        bus.DataIn  = DW'($urandom);
        m_err       = 1'b1;
      end
      tick;
      bus.InValid = 1'b0;
      cap_d[k] = bus.DataOut;
      cap_r[k] = bus.Rank;
      check("emit_ov",   32'(bus.OutValid), 32'd1);
      check("emit_data", 32'(bus.DataOut), 32'({ev[k], IDX_W'(k)}));
      check("emit_rank", 32'(bus.Rank), 32'(er[k]));
      check("emit_busy", 32'(bus.Busy), 32'(k != N - 1));
      check("emit_err",  32'(bus.Error), 32'(m_err));
    end
  endtask

  task automatic check_nominal;
    for (int k = 0; k < N; k++) begin
      check("nom_data", 32'(cap_d[k]), 32'({tab_v[k], IDX_W'(k)}));
      check("nom_rank", 32'(cap_r[k]), 32'(tab_r[k]));
    end
  endtask

  task automatic idle_check;
    tick;
    check("idle_ov",   32'(bus.OutValid), 32'd0);
    check("idle_busy", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int unsigned j;
    logic [DW-1:0] t;
    nom = '{{8'd246, 4'd0}, {8'd234, 4'd2}, {8'd229, 4'd7}, {8'd198, 4'd8},
            {8'd151, 4'd5}, {8'd142, 4'd9}, {8'd141, 4'd6}, {8'd140, 4'd10},
            {8'd123, 4'd11}, {8'd104, 4'd4}, {8'd82, 4'd3}, {8'd64, 4'd1}};
    tab_v = '{8'd246, 8'd64, 8'd234, 8'd82, 8'd104, 8'd151,
              8'd141, 8'd229, 8'd198, 8'd142, 8'd140, 8'd123};
    tab_r = '{4'd0, 4'd11, 4'd1, 4'd10, 4'd9, 4'd4, 4'd6, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8};
    for (int i = 0; i < N; i++) rev[i] = nom[N - 1 - i];
    m_err = 1'b0;

    // Nominal frame, then an ascending frame back to back
    do_reset;
    run_frame(nom, -1, 0, -1, -1);
    check_nominal;
    run_frame(rev, -1, 0, -1, -1);
    check("b2b_r0", 32'(cap_r[0]), 32'd11);
    check("b2b_r1", 32'(cap_r[1]), 32'd0);
    check("b2b_err", 32'(bus.Error), 32'd0);
    idle_check;

    // Gapped input
    do_reset;
    run_frame(nom, 5, 3, -1, -1);
    check_nominal;

    // Duplicate index
    do_reset;
    wbuf = nom;
    wbuf[4] = {8'd151, 4'd2};
    run_frame(wbuf, -1, 0, -1, -1);
    check("dup_d2", 32'(cap_d[2]), 32'({8'd234, 4'd2}));
    check("dup_r2", 32'(cap_r[2]), 32'd1);
    check("dup_d5", 32'(cap_d[5]), 32'({8'd0, 4'd5}));
    check("dup_r5", 32'(cap_r[5]), 32'hF);
    check("dup_err", 32'(bus.Error), 32'd1);

    // Overrun during the third emit cycle
    do_reset;
    run_frame(nom, -1, 0, 2, -1);
    check_nominal;
    check("ovr_err", 32'(bus.Error), 32'd1);

    // Reset sampled at E5, then a clean frame
    do_reset;
    run_frame(nom, -1, 0, -1, 4);
    run_frame(nom, -1, 0, -1, -1);
    check_nominal;
    idle_check;

    // Randomized frames: shuffled indices, occasional corruption, gaps, overruns
    do_reset;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N; i++) wbuf[i] = {VAL_W'($urandom), IDX_W'(i)};
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = wbuf[i];
        wbuf[i] = wbuf[j];
        wbuf[j] = t;
      end
      if ($urandom_range(3, 0) == 0)
        wbuf[$urandom_range(N - 1, 0)][IDX_W-1:0] = IDX_W'($urandom_range(15, 0));
      run_frame(wbuf,
                ($urandom_range(1, 0) == 1) ? int'($urandom_range(N - 1, 1)) : -1,
                int'($urandom_range(4, 1)),
                ($urandom_range(4, 0) == 0) ? int'($urandom_range(N - 1, 0)) : -1,
                ($urandom_range(9, 0) == 0) ? int'($urandom_range(N - 1, 0)) : -1);
      if ($urandom_range(1, 0) == 1) idle_check;
      if ($urandom_range(5, 0) == 0) do_reset;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
